xadc_sample_buffer: RTL and testbench

- Sits directly downstream of the XADC conversion/DRP interface.
- Consumes end-of-conversion events, channel IDs and DRP read data for the four auxiliary analog inputs.
- Averages 2^AVG_LOG2 conversions per channel and holds the results in per-channel registers with sticky new-data flags.
- Presents the results to the Microblaze through the standard slot interface.

---
 rtl/xadc_pkg.sv | 45 ++++
 rtl/xadc_sample_buffer_if.sv | 26 ++
 rtl/xadc_chan_accum.sv | 77 +++++++
 rtl/xadc_sample_buffer.sv | 126 ++++++++++++
 tb/tb_xadc_sample_buffer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC auxiliary-input sample buffer.
//   - XADC channel numbers of the four captured auxiliary inputs
//   - slot register addresses
//   - capture FSM state type
//   - channel-to-slot-index lookup
package xadc_pkg;

  localparam logic [4:0] CH_AUX6  = 5'h16;
  localparam logic [4:0] CH_AUX14 = 5'h1E;
  localparam logic [4:0] CH_AUX7  = 5'h17;
  localparam logic [4:0] CH_AUX15 = 5'h1F;

  localparam logic [4:0] REG_DATA0  = 5'd0;
  localparam logic [4:0] REG_DATA1  = 5'd1;
  localparam logic [4:0] REG_DATA2  = 5'd2;
  localparam logic [4:0] REG_DATA3  = 5'd3;
  localparam logic [4:0] REG_STATUS = 5'd4;
  localparam logic [4:0] REG_CTRL   = 5'd5;
  localparam logic [4:0] REG_ERR    = 5'd6;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned SAMPLE_W = 12;

  typedef enum logic [1:0] {IDLE, WAIT, ACCUM} state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } chan_map_t;

  function automatic chan_map_t map_channel(input logic [4:0] ch);
    chan_map_t m;
    m.hit = 1'b1;
    m.idx = 2'd0;
    case (ch)
      CH_AUX6:  m.idx = 2'd0;
      CH_AUX14: m.idx = 2'd1;
      CH_AUX7:  m.idx = 2'd2;
      CH_AUX15: m.idx = 2'd3;
      default:  m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/xadc_sample_buffer_if.sv
// Bus bundle for xadc_sample_buffer.
//   Slot side : cs, read, write, reg_addr, wr_data -> rd_data
//   XADC side : eoc, channel, drdy, adc_do
// master = Microblaze slot + XADC drivers, slave = the sample buffer.
interface xadc_sample_buffer_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        eoc;
  logic [4:0]  channel;
  logic        drdy;
  logic [15:0] adc_do;

  modport master (
    output cs, read, write, reg_addr, wr_data, eoc, channel, drdy, adc_do,
    input  rd_data
  );

  modport slave (
    input  cs, read, write, reg_addr, wr_data, eoc, channel, drdy, adc_do,
    output rd_data
  );
endinterface

// File: rtl/xadc_chan_accum.sv
// Per-channel averaging accumulator.
//   clk, reset : clock, async active-high reset
//   add_en     : add 'sample' this cycle
//   sample     : 12-bit conversion result
//   clr        : zero acc, cnt, avg and new flag (wins over everything)
//   rd_clr     : clear the new flag (loses to a same-cycle set)
//   avg        : last completed average
//   new_flag   : sticky "average updated" flag
module xadc_chan_accum
  import xadc_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                add_en,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                clr,
  input  logic                rd_clr,
  output logic [SAMPLE_W-1:0] avg,
  output logic                new_flag
);

  localparam int unsigned AccW = SAMPLE_W + AVG_LOG2;
  localparam int unsigned CntW = AVG_LOG2 + 1;
  localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG2) - 1);

  logic [AccW-1:0]     acc_q, acc_d, sum;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] avg_q, avg_d;
  logic                new_q, new_d;

  // 2^AVG_LOG2 full-scale samples fit exactly in AccW bits.
  assign sum = acc_q + AccW'(sample);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    avg_d = avg_q;
    new_d = new_q;
    if (rd_clr) new_d = 1'b0;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
      avg_d = '0;
      new_d = 1'b0;
    end else if (add_en) begin
      if (cnt_q == CntLast) begin
        avg_d = sum[AccW-1:AVG_LOG2];
        acc_d = '0;
        cnt_d = '0;
        new_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      avg_q <= '0;
      new_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      avg_q <= avg_d;
      new_q <= new_d;
    end
  end

  assign avg      = avg_q;
  assign new_flag = new_q;

endmodule

// File: rtl/xadc_sample_buffer.sv
// XADC auxiliary-input sample buffer.
// Captures DRP results for aux6/14/7/15 after each end-of-conversion, averages
// 2^AVG_LOG2 samples per channel and exposes them on the Microblaze slot bus.
//   clk, reset : clock, async active-high reset
//   bus        : slot + XADC signals (xadc_sample_buffer_if.slave)
module xadc_sample_buffer
  import xadc_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  xadc_sample_buffer_if.slave   bus
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  state_t              state_q;
  logic [1:0]          idx_q;
  logic [TimerW-1:0]   timer_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic [15:0]         err_cnt_q;
  logic                enable_q;

  logic                slot_rd, slot_wr, ctrl_wr, err_wr, clear;
  logic                timeout, eoc_err;
  logic [16:0]         err_sum;
  chan_map_t           eoc_map;
  logic [SAMPLE_W-1:0] avg [NUM_CH];
  logic [NUM_CH-1:0]   new_flags;

  assign slot_rd = bus.cs & bus.read;
  assign slot_wr = bus.cs & bus.write;
  assign ctrl_wr = slot_wr && (bus.reg_addr == REG_CTRL);
  assign err_wr  = slot_wr && (bus.reg_addr == REG_ERR);
  assign clear   = ctrl_wr & bus.wr_data[1];
  assign eoc_map = map_channel(bus.channel);

  // A clear aborts the wait, so a coincident expiry is not an error.
  assign timeout = (state_q == WAIT) && !bus.drdy && (timer_q == TimerLast) && !clear;
  assign eoc_err = (state_q == WAIT) && bus.eoc;
  assign err_sum = {1'b0, err_cnt_q} + 17'(timeout) + 17'(eoc_err);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      timer_q  <= '0;
      sample_q <= '0;
    end else if (clear) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.eoc && enable_q && eoc_map.hit) begin
            idx_q   <= eoc_map.idx;
            timer_q <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.drdy) begin
            sample_q <= bus.adc_do[15:4];
            state_q  <= ACCUM;
          end else if (timer_q == TimerLast) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        ACCUM:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (err_wr) begin
      err_cnt_q <= '0;
    end else if (err_sum[16]) begin
      err_cnt_q <= 16'hFFFF;
    end else begin
      err_cnt_q <= err_sum[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= 1'b1;
    end else if (ctrl_wr) begin
      enable_q <= bus.wr_data[0];
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
    xadc_chan_accum #(
      .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
      .clk      (clk),
      .reset    (reset),
      .add_en   ((state_q == ACCUM) && (idx_q == 2'(n))),
      .sample   (sample_q),
      .clr      (clear),
      .rd_clr   (slot_rd && (bus.reg_addr == 5'(n))),
      .avg      (avg[n]),
      .new_flag (new_flags[n])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    case (bus.reg_addr)
      REG_DATA0, REG_DATA1, REG_DATA2, REG_DATA3:
        bus.rd_data = {15'h0, avg[bus.reg_addr[1:0]], 4'h0, new_flags[bus.reg_addr[1:0]]};
      REG_STATUS: bus.rd_data = {28'h0, new_flags};
      REG_CTRL:   bus.rd_data = {31'h0, enable_q};
      REG_ERR:    bus.rd_data = {16'h0, err_cnt_q};
      default:    bus.rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_xadc_sample_buffer.sv
// Directed bench for xadc_sample_buffer with a reference model and a
// scoreboard queue of expected register reads.
module tb_xadc_sample_buffer;

  localparam int unsigned AVG_LOG2 = 3;
  localparam int unsigned TIMEOUT  = 64;
  localparam int unsigned NAVG     = 1 << AVG_LOG2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xadc_sample_buffer_if bus ();

  xadc_sample_buffer #(
    .AVG_LOG2 (AVG_LOG2),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int unsigned m_acc [4];
  int unsigned m_cnt [4];
  logic [11:0] m_avg [4];
  logic [3:0]  m_new;
  logic        m_en;
  logic [15:0] m_err;

  function automatic int map_ch(input logic [4:0] ch);
    case (ch)
      5'h16:   return 0;
      5'h1E:   return 1;
      5'h17:   return 2;
      5'h1F:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] model_reg(input int a);
    case (a)
      0, 1, 2, 3: return {15'h0, m_avg[a], 4'h0, m_new[a]};
      4:          return {28'h0, m_new};
      5:          return {31'h0, m_en};
      6:          return {16'h0, m_err};
      default:    return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 0;
      m_cnt[i] = 0;
      m_avg[i] = '0;
    end
    m_new = '0;
  endtask

  task automatic model_reset();
    model_clear();
    m_en  = 1'b1;
    m_err = '0;
  endtask

  task automatic model_sample(input logic [4:0] ch, input logic [15:0] data);
    int idx;
    idx = map_ch(ch);
    if (idx >= 0 && m_en) begin
      m_acc[idx] += 32'(data[15:4]);
      m_cnt[idx] += 1;
      if (m_cnt[idx] == NAVG) begin
        m_avg[idx] = 12'(m_acc[idx] / NAVG);
        m_acc[idx] = 0;
        m_cnt[idx] = 0;
        m_new[idx] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    total++;
    assert (bus.rd_data === e.val) else begin
      bad++;
      $error("FAIL %s: rd_data=%h expected=%h", e.tag, bus.rd_data, e.val);
    end
  endtask

  // Reads register a; with strobe set the read side effect lands on the next edge.
  task automatic read_reg(input int a, input logic strobe, input string tag);
    bus.reg_addr = 5'(a);
    bus.cs       = strobe;
    bus.read     = strobe;
    sb.push_back('{tag, model_reg(a)});
    @(negedge clk);
    check_front();
    tick();
    bus.cs   = 1'b0;
    bus.read = 1'b0;
    if (strobe && a < 4) m_new[a] = 1'b0;
  endtask

  task automatic write_reg(input int a, input logic [31:0] d);
    bus.reg_addr = 5'(a);
    bus.wr_data  = d;
    bus.cs       = 1'b1;
    bus.write    = 1'b1;
    tick();
    bus.cs    = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic pair(input logic [4:0] ch, input logic [15:0] data);
    bus.channel = ch;
    bus.eoc     = 1'b1;
    tick();
    bus.eoc = 1'b0;
    tick();
    bus.adc_do = data;
    bus.drdy   = 1'b1;
    tick();
    bus.drdy = 1'b0;
    tick();
    tick();
    model_sample(ch, data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.cs       = 1'b0;
    bus.read     = 1'b0;
    bus.write    = 1'b0;
    bus.reg_addr = '0;
    bus.wr_data  = '0;
    bus.eoc      = 1'b0;
    bus.channel  = '0;
    bus.drdy     = 1'b0;
    bus.adc_do   = '0;
    reset        = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int a = 0; a < 7; a++) read_reg(a, 1'b0, $sformatf("reset_reg%0d", a));
    read_reg(7, 1'b0, "unmapped_reg7");

    // Ramp on aux6: average of 0x800..0x807 is 0x803
    for (int i = 0; i < 8; i++) pair(5'h16, 16'h8000 + 16'(16 * i));
    read_reg(0, 1'b1, "aux6_avg_first_read");
    read_reg(0, 1'b1, "aux6_new_cleared");

    // Timeout on aux15
    bus.channel = 5'h1F;
    bus.eoc     = 1'b1;
    tick();
    bus.eoc = 1'b0;
    repeat (TIMEOUT + 4) tick();
    m_err = m_err + 16'd1;
    read_reg(6, 1'b0, "err_after_timeout");

    // Unmapped channel ignored
    pair(5'h03, 16'h5550);
    read_reg(4, 1'b1, "status_after_unmapped");
    read_reg(6, 1'b0, "err_after_unmapped");

    // aux15 accumulates normally after the timeout
    for (int i = 0; i < 8; i++) pair(5'h1F, 16'h1230 + 16'(16'h0100 * i));
    read_reg(3, 1'b1, "aux15_avg");

    // aux7: read of reg 2 coincides with the completing ACCUM cycle
    for (int i = 0; i < 7; i++) pair(5'h17, 16'h0100 + 16'(16'h0230 * i));
    bus.channel = 5'h17;
    bus.eoc     = 1'b1;
    tick();
    bus.eoc = 1'b0;
    tick();
    bus.adc_do = 16'h0100 + 16'(16'h0230 * 7);
    bus.drdy   = 1'b1;
    tick();
    bus.drdy = 1'b0;
    read_reg(2, 1'b1, "aux7_before_set");
    model_sample(5'h17, 16'h0100 + 16'(16'h0230 * 7));
    tick();
    read_reg(2, 1'b0, "aux7_set_wins");
    read_reg(4, 1'b1, "status_aux7_only");

    // Clear mid-accumulation on aux14, then disabled capture ignored
    for (int i = 0; i < 4; i++) pair(5'h1E, 16'h4000);
    write_reg(5, 32'h2);
    m_en = 1'b0;
    model_clear();
    read_reg(5, 1'b0, "ctrl_disabled");
    read_reg(2, 1'b0, "aux7_cleared");
    pair(5'h1E, 16'h7770);
    write_reg(5, 32'h1);
    m_en = 1'b1;
    read_reg(5, 1'b0, "ctrl_enabled");
    for (int i = 0; i < 8; i++) pair(5'h1E, 16'hFFF0);
    read_reg(1, 1'b0, "aux14_fullscale");

    // Error counter write-clear, then eoc during WAIT counts as an error
    write_reg(6, 32'h0);
    m_err = '0;
    read_reg(6, 1'b0, "err_write_clear");
    bus.channel = 5'h16;
    bus.eoc     = 1'b1;
    tick();
    bus.channel = 5'h03;
    tick();
    bus.eoc = 1'b0;
    m_err   = m_err + 16'd1;
    read_reg(6, 1'b0, "err_eoc_in_wait");

    // Async reset while in WAIT
    #2 reset = 1'b1;
    model_reset();
    for (int a = 0; a < 7; a++) read_reg(a, 1'b0, $sformatf("inreset_reg%0d", a));
    reset = 1'b0;
    bus.adc_do = 16'hABC0;
    bus.drdy   = 1'b1;
    tick();
    bus.drdy = 1'b0;
    tick();
    for (int a = 0; a < 7; a++) read_reg(a, 1'b0, $sformatf("postreset_reg%0d", a));
    for (int i = 0; i < 8; i++) pair(5'h16, 16'h0F00);
    read_reg(0, 1'b0, "aux6_after_reset");

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: entries=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
